csr_seq: RTL

Multi-cycle sequencer that owns every port of the machine-mode CSR file and serialises all accesses to it. It handles CSRRW/CSRRS/CSRRC read-modify-write, ECALL and illegal-CSR trap entry, MRET return and, optionally, machine timer interrupts. It sits between the EXU and the CSR file, and returns read data plus a PC redirect to the EXU over a valid/ready response channel.

---
 rtl/csr_seq.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_seq.sv
// csr_seq - multi-cycle sequencer owning all ports of the machine-mode CSR file.
//
// Serialises CSRRW/CSRRS/CSRRC read-modify-write, ECALL / illegal-CSR trap
// entry and MRET return, then hands read data and a next-PC to the EXU over
// a valid/ready response channel.
//
// Optional feature: define CSR_SEQ_IRQ_EN to add the machine timer interrupt
// inputs (irq, irq_en, irq_pc). Without it only synchronous traps exist.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 request channel from the EXU (valid/ready)
//   rsp_*                 response channel to the EXU (valid/ready)
//   csr_wen/addr/wdata    CSR write port, csr_rdata is combinational read data
//   csr_intr/_no/_epc     trap-entry strobe with mcause / mepc values
//   csr_mtvec, csr_mepc   current trap vector and return PC from the CSR file
//   csr_mret              return strobe
//   irq, irq_en, irq_pc   timer request, mstatus.MIE, resume PC (macro only)

module csr_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [11:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_src,
    input  logic [DATA_WIDTH-1:0] req_pc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_redirect,
    output logic [DATA_WIDTH-1:0] rsp_npc,
    output logic                  csr_wen,
    output logic [DATA_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_intr,
    output logic [DATA_WIDTH-1:0] csr_intr_no,
    output logic [DATA_WIDTH-1:0] csr_intr_epc,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    output logic                  csr_mret,
    input  logic [DATA_WIDTH-1:0] csr_mepc
`ifdef CSR_SEQ_IRQ_EN
    ,
    input  logic                  irq,
    input  logic                  irq_en,
    input  logic [DATA_WIDTH-1:0] irq_pc
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_TRAP = 3'd3,
        ST_RET  = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    localparam logic [2:0] OP_RW    = 3'd0;
    localparam logic [2:0] OP_RS    = 3'd1;
    localparam logic [2:0] OP_RC    = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [DATA_WIDTH-1:0] ZERO        = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] PC_STEP     = {{(DATA_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [DATA_WIDTH-1:0] CAUSE_ILL   = {{(DATA_WIDTH-4){1'b0}}, 4'd2};
    localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL = {{(DATA_WIDTH-4){1'b0}}, 4'd11};
    // Interrupt flag in the MSB, exception code 7 (machine timer).
    localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ   = {1'b1, {(DATA_WIDTH-4){1'b0}}, 3'b111};

    // Only the CSRs this file implements; anything else raises an illegal-instruction trap.
    function automatic logic csr_is_impl(input logic [11:0] addr);
        case (addr)
            12'h300, 12'h305, 12'h341, 12'h342: csr_is_impl = 1'b1;
            default:                            csr_is_impl = 1'b0;
        endcase
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    irq_take_s;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   irq_pc_s;
    logic [DATA_WIDTH-1:0]   cause_s;
    logic [DATA_WIDTH-1:0]   epc_s;
    logic [DATA_WIDTH-1:0]   new_val_s;
    logic                    skip_wr_s;

    logic [2:0]              op_r;
    logic [11:0]             addr_r;
    logic [DATA_WIDTH-1:0]   src_r;
    logic [DATA_WIDTH-1:0]   pc_r;
    logic [DATA_WIDTH-1:0]   old_r;

    logic                    csr_wen_r,      csr_wen_nxt_s;
    logic [DATA_WIDTH-1:0]   csr_addr_r,     csr_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   csr_wdata_r,    csr_wdata_nxt_s;
    logic                    csr_intr_r,     csr_intr_nxt_s;
    logic [DATA_WIDTH-1:0]   csr_intr_no_r,  csr_intr_no_nxt_s;
    logic [DATA_WIDTH-1:0]   csr_intr_epc_r, csr_intr_epc_nxt_s;
    logic                    csr_mret_r,     csr_mret_nxt_s;
    logic                    rsp_valid_r,    rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r,    rsp_rdata_nxt_s;
    logic                    rsp_redirect_r, rsp_redirect_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_npc_r,      rsp_npc_nxt_s;

`ifdef CSR_SEQ_IRQ_EN
    assign irq_take_s = (state_r == ST_IDLE) & irq & irq_en;
    assign irq_pc_s   = irq_pc;
`else
    assign irq_take_s = 1'b0;
    assign irq_pc_s   = ZERO;
`endif

    // A pending interrupt blocks acceptance so the request waits for the trap to finish.
    assign req_ready = (state_r == ST_IDLE) & ~irq_take_s;
    assign accept_s  = req_valid & req_ready;

    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign rsp_redirect = rsp_redirect_r;
    assign rsp_npc      = rsp_npc_r;
    assign csr_wen      = csr_wen_r;
    assign csr_addr     = csr_addr_r;
    assign csr_wdata    = csr_wdata_r;
    assign csr_intr     = csr_intr_r;
    assign csr_intr_no  = csr_intr_no_r;
    assign csr_intr_epc = csr_intr_epc_r;
    assign csr_mret     = csr_mret_r;

    // RS/RC with a zero mask are pure reads and must not disturb the CSR.
    assign skip_wr_s = (op_r != OP_RW) & (src_r == ZERO);

    // Read-modify-write result, valid while in RD where csr_rdata holds the old value.
    always_comb begin
        new_val_s = src_r;
        case (op_r)
            OP_RW:   new_val_s = src_r;
            OP_RS:   new_val_s = csr_rdata | src_r;
            OP_RC:   new_val_s = csr_rdata & ~src_r;
            default: new_val_s = src_r;
        endcase
    end

    // Trap cause and return PC chosen at the IDLE decision point.
    always_comb begin
        cause_s = CAUSE_ILL;
        epc_s   = req_pc;
        if (irq_take_s) begin
            cause_s = CAUSE_IRQ;
            epc_s   = irq_pc_s;
        end else if (req_op == OP_ECALL) begin
            cause_s = CAUSE_ECALL;
            epc_s   = req_pc;
        end else begin
            cause_s = CAUSE_ILL;
            epc_s   = req_pc;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (irq_take_s) begin
                    state_nxt_s = ST_TRAP;
                end else if (accept_s) begin
                    case (req_op)
                        OP_RW, OP_RS, OP_RC: state_nxt_s = csr_is_impl(req_addr) ? ST_RD : ST_TRAP;
                        OP_ECALL:            state_nxt_s = ST_TRAP;
                        OP_MRET:             state_nxt_s = ST_RET;
                        default:             state_nxt_s = ST_TRAP;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD:   state_nxt_s = skip_wr_s ? ST_RSP : ST_WR;
            ST_WR:   state_nxt_s = ST_RSP;
            ST_TRAP: state_nxt_s = ST_RSP;
            ST_RET:  state_nxt_s = ST_RSP;
            ST_RSP:  state_nxt_s = rsp_ready ? ST_IDLE : ST_RSP;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        csr_wen_nxt_s      = 1'b0;
        csr_addr_nxt_s     = ZERO;
        csr_wdata_nxt_s    = ZERO;
        csr_intr_nxt_s     = 1'b0;
        csr_intr_no_nxt_s  = ZERO;
        csr_intr_epc_nxt_s = ZERO;
        csr_mret_nxt_s     = 1'b0;
        rsp_valid_nxt_s    = 1'b0;
        rsp_rdata_nxt_s    = ZERO;
        rsp_redirect_nxt_s = 1'b0;
        rsp_npc_nxt_s      = ZERO;
        case (state_nxt_s)
            // RD is only entered from IDLE, so the address comes straight from the request.
            ST_RD: csr_addr_nxt_s = {{(DATA_WIDTH-12){1'b0}}, req_addr};
            ST_WR: begin
                csr_wen_nxt_s   = 1'b1;
                csr_addr_nxt_s  = {{(DATA_WIDTH-12){1'b0}}, addr_r};
                csr_wdata_nxt_s = new_val_s;
            end
            ST_TRAP: begin
                csr_intr_nxt_s     = 1'b1;
                csr_intr_no_nxt_s  = cause_s;
                csr_intr_epc_nxt_s = epc_s;
            end
            ST_RET: csr_mret_nxt_s = 1'b1;
            ST_RSP: begin
                rsp_valid_nxt_s = 1'b1;
                case (state_r)
                    ST_RD: begin
                        rsp_rdata_nxt_s = csr_rdata;
                        rsp_npc_nxt_s   = pc_r + PC_STEP;
                    end
                    ST_WR: begin
                        rsp_rdata_nxt_s = old_r;
                        rsp_npc_nxt_s   = pc_r + PC_STEP;
                    end
                    ST_TRAP: begin
                        rsp_redirect_nxt_s = 1'b1;
                        rsp_npc_nxt_s      = csr_mtvec;
                    end
                    ST_RET: begin
                        rsp_redirect_nxt_s = 1'b1;
                        rsp_npc_nxt_s      = csr_mepc;
                    end
                    ST_RSP: begin
                        rsp_rdata_nxt_s    = rsp_rdata_r;
                        rsp_redirect_nxt_s = rsp_redirect_r;
                        rsp_npc_nxt_s      = rsp_npc_r;
                    end
                    default: rsp_valid_nxt_s = 1'b1;
                endcase
            end
            default: csr_wen_nxt_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_wen_r      <= 1'b0;
            csr_addr_r     <= ZERO;
            csr_wdata_r    <= ZERO;
            csr_intr_r     <= 1'b0;
            csr_intr_no_r  <= ZERO;
            csr_intr_epc_r <= ZERO;
            csr_mret_r     <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_rdata_r    <= ZERO;
            rsp_redirect_r <= 1'b0;
            rsp_npc_r      <= ZERO;
        end else begin
            csr_wen_r      <= csr_wen_nxt_s;
            csr_addr_r     <= csr_addr_nxt_s;
            csr_wdata_r    <= csr_wdata_nxt_s;
            csr_intr_r     <= csr_intr_nxt_s;
            csr_intr_no_r  <= csr_intr_no_nxt_s;
            csr_intr_epc_r <= csr_intr_epc_nxt_s;
            csr_mret_r     <= csr_mret_nxt_s;
            rsp_valid_r    <= rsp_valid_nxt_s;
            rsp_rdata_r    <= rsp_rdata_nxt_s;
            rsp_redirect_r <= rsp_redirect_nxt_s;
            rsp_npc_r      <= rsp_npc_nxt_s;
        end
    end

    // Request capture on accept and old-value capture during RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= 3'd0;
            addr_r <= 12'h000;
            src_r  <= ZERO;
            pc_r   <= ZERO;
            old_r  <= ZERO;
        end else if (state_r == ST_IDLE && accept_s) begin
            op_r   <= req_op;
            addr_r <= req_addr;
            src_r  <= req_src;
            pc_r   <= req_pc;
        end else if (state_r == ST_RD) begin
            old_r <= csr_rdata;
        end else begin
            old_r <= old_r;
        end
    end

endmodule
